// File: rtl/rib_sram_resp.sv
// RIB slave-side SRAM responder with a fixed number of wait states.
// A request is accepted in IDLE, held off for WAIT_CYCLES cycles in total
// (IDLE request cycle plus WAIT), and completed in a single RESP cycle
// that pulses ack_o and, for accesses outside the window, err_o.
module rib_sram_resp #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hold_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WIN_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  CNT_INIT  = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               latch_en;

    logic               we_q;
    logic               hit_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [DEPTH];

    // Offset from the window base; addresses below the base wrap to a
    // large value and therefore fall outside the window.
    logic [31:0]        offset;
    logic               hit;
    logic [IDX_W-1:0]   idx;

    assign offset = addr_i - BASE_ADDR;
    assign hit    = offset < WIN_BYTES;
    assign idx    = offset[IDX_W+1:2];

    // Control state: FSM state and wait counter, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, one-cycle RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_INIT;
                    state_d  = (WAIT_CYCLES > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Request capture: bus inputs are frozen at acceptance so later
    // changes during the wait period have no effect.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            we_q    <= we_i;
            hit_q   <= hit;
            idx_q   <= idx;
            wdata_q <= data_i;
        end
    end

    // SRAM write at the end of the RESP cycle; a reset during the access
    // forces IDLE first, so an interrupted write never lands.
    always_ff @(posedge clk) begin
        if (state_q == S_RESP && we_q && hit_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Output decode: only hold_o sees req_i combinationally.
    always_comb begin
        hold_o = 1'b0;
        ack_o  = 1'b0;
        err_o  = 1'b0;
        data_o = 32'd0;
        case (state_q)
            S_IDLE: hold_o = req_i;
            S_WAIT: hold_o = 1'b1;
            S_RESP: begin
                ack_o = 1'b1;
                err_o = !hit_q;
                if (hit_q && !we_q) begin
                    data_o = mem[idx_q];
                end
            end
            default: hold_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rib_sram_resp.sv
// Bench for rib_sram_resp: main instance with two wait states, plus
// one-wait-state and fifteen-wait-state instances for timing corners.
module tb_rib_sram_resp;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          WC   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] addr_i = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [31:0] data_o;
    logic        hold_o, ack_o, err_o;

    logic        req_x [2];
    logic        we_x  [2];
    logic [31:0] addr_x [2];
    logic [31:0] data_x [2];
    logic [63:0] dflat;
    logic [1:0]  hold_x, ack_x, err_x;

    int n_cmp = 0;
    int n_err = 0;
    int hcnt  = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;
    exp_t sbq [$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;
    vec_t vecs [12];

    always #5 clk = ~clk;

    rib_sram_resp #(.BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .data_i(data_i), .data_o(data_o), .hold_o(hold_o), .ack_o(ack_o),
        .err_o(err_o)
    );

    rib_sram_resp #(.BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .rst(rst), .req_i(req_x[0]), .we_i(we_x[0]), .addr_i(addr_x[0]),
        .data_i(data_x[0]), .data_o(dflat[31:0]), .hold_o(hold_x[0]), .ack_o(ack_x[0]),
        .err_o(err_x[0])
    );

    rib_sram_resp #(.BASE_ADDR(BASE), .DEPTH(1024), .WAIT_CYCLES(15)) dut_w15 (
        .clk(clk), .rst(rst), .req_i(req_x[1]), .we_i(we_x[1]), .addr_i(addr_x[1]),
        .data_i(data_x[1]), .data_o(dflat[63:32]), .hold_o(hold_x[1]), .ack_o(ack_x[1]),
        .err_o(err_x[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input int w, input int k);
        return 32'hC0DE_0000 + 32'(w * 256 + k * 17);
    endfunction

    // Scoreboard side: every ack on the main instance pops one expectation.
    always @(negedge clk) begin
        if (!rst) begin
            hcnt = 0;
        end else begin
            if (hold_o) hcnt++;
            if (ack_o) begin
                chk("hold_cycles", 32'(hcnt), 32'(WC));
                hcnt = 0;
                if (sbq.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("rdata", data_o, e.d);
                    chk("err", {31'd0, err_o}, {31'd0, e.e});
                end
            end
        end
    end

    // Single access on the main instance, starting just after a rising edge.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] exp_d, input logic exp_e);
        int lat;
        bit got;
        exp_t e;
        e.d = exp_d;
        e.e = exp_e;
        sbq.push_back(e);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = addr;
        data_i = data;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        lat = 0;
        got = 1'b0;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            lat++;
            if (ack_o) got = 1'b1;
        end
        chk("ack_seen", {31'd0, got}, 32'd1);
        chk("latency", 32'(lat), 32'(WC));
        @(posedge clk);
        #1;
    endtask

    // Four back-to-back accesses on one of the side instances.
    task automatic b2b(input int w, input int wc, input logic wr);
        int gap, hc;
        bit got;
        req_x[w]  = 1'b1;
        we_x[w]   = wr;
        addr_x[w] = BASE;
        data_x[w] = pat(w, 0);
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            hc  = 0;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                gap++;
                if (hold_x[w]) hc++;
                if (ack_x[w]) got = 1'b1;
            end
            chk("b2b_ack_seen", {31'd0, got}, 32'd1);
            chk("b2b_ack_period", 32'(gap), 32'(wc + 1));
            chk("b2b_hold_cycles", 32'(hc), 32'(wc));
            chk("b2b_err", {31'd0, err_x[w]}, 32'd0);
            if (!wr) chk("b2b_rdata", dflat[w*32 +: 32], pat(w, k));
            if (k < 3) begin
                addr_x[w] = BASE + 32'((k + 1) * 4);
                data_x[w] = pat(w, k + 1);
            end else begin
                req_x[w] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_x[i] = 1'b0; we_x[i] = 1'b0; addr_x[i] = 32'd0; data_x[i] = 32'd0;
        end

        vecs[0]  = '{1'b1, BASE + 32'h10,   32'hDEAD_BEEF, 32'd0,         1'b0};
        vecs[1]  = '{1'b0, BASE + 32'h10,   32'd0,         32'hDEAD_BEEF, 1'b0};
        vecs[2]  = '{1'b1, BASE + 32'hFFC,  32'h5A5A_0FFC, 32'd0,         1'b0};
        vecs[3]  = '{1'b0, BASE + 32'hFFC,  32'd0,         32'h5A5A_0FFC, 1'b0};
        vecs[4]  = '{1'b0, BASE + 32'h1000, 32'd0,         32'd0,         1'b1};
        vecs[5]  = '{1'b0, BASE - 32'h4,    32'd0,         32'd0,         1'b1};
        vecs[6]  = '{1'b1, BASE,            32'h0000_0A0A, 32'd0,         1'b0};
        vecs[7]  = '{1'b1, BASE + 32'h1000, 32'h0000_0BAD, 32'd0,         1'b1};
        vecs[8]  = '{1'b0, BASE,            32'd0,         32'h0000_0A0A, 1'b0};
        vecs[9]  = '{1'b1, BASE + 32'h8,    32'h1234_5678, 32'd0,         1'b0};
        vecs[10] = '{1'b0, BASE + 32'h13,   32'd0,         32'hDEAD_BEEF, 1'b0};
        vecs[11] = '{1'b1, BASE + 32'h24,   32'h2424_2424, 32'd0,         1'b0};

        // Reset state.
        #12;
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        chk("rst_ack",  {31'd0, ack_o},  32'd0);
        chk("rst_err",  {31'd0, err_o},  32'd0);
        chk("rst_data", data_o,          32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_d, vecs[i].exp_e);
        end

        // Write to 0x20 while the bus inputs change during the wait state.
        begin
            exp_t e;
            e.d = 32'd0;
            e.e = 1'b0;
            sbq.push_back(e);
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'h20; data_i = 32'h1;
        @(posedge clk);
        #1;
        addr_i = BASE + 32'h24; data_i = 32'hFF; we_i = 1'b0;
        chk("toggle_hold_wait", {31'd0, hold_o}, 32'd1);
        @(posedge clk);
        #1;
        req_i = 1'b0;
        chk("toggle_ack", {31'd0, ack_o}, 32'd1);
        @(posedge clk);
        #1;
        access(1'b0, BASE + 32'h20, 32'd0, 32'h0000_0001, 1'b0);
        access(1'b0, BASE + 32'h24, 32'd0, 32'h2424_2424, 1'b0);

        // Reset during the wait state of a write to 0x8.
        req_i = 1'b1; we_i = 1'b1; addr_i = BASE + 32'h8; data_i = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        req_i = 1'b0;
        chk("pre_rst_hold", {31'd0, hold_o}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_hold", {31'd0, hold_o}, 32'd0);
        chk("midrst_ack",  {31'd0, ack_o},  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        access(1'b0, BASE + 32'h8, 32'd0, 32'h1234_5678, 1'b0);

        // Back-to-back timing on the one- and fifteen-wait-state builds.
        b2b(0, 1, 1'b1);
        b2b(0, 1, 1'b0);
        b2b(1, 15, 1'b1);
        b2b(1, 15, 1'b0);

        repeat (4) @(posedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
